// File: rtl/ring_stim_gen.sv
// ring_stim_gen: programmable square-wave source standing in for a ring
// oscillator. Emits a burst of cfg_edges rising edges (or runs forever when
// cfg_edges is 0) with a half-period of cfg_half_period clk cycles.
//
// Handshake: a configuration transfers on a rising clk edge where
// cfg_valid && cfg_ready. cfg_ready is high only in IDLE, with stop and rst
// low; offers made while busy are dropped, never buffered. cfg_valid may be
// held high without restarting a running burst.
module ring_stim_gen #(
   parameter int PW = 8,
   parameter int NW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic [PW-1:0] cfg_half_period,
   input  logic [NW-1:0] cfg_edges,
   input  logic          stop,
   output logic          ring_out,
   output logic          busy,
   output logic          done,
   output logic [NW-1:0] edges_sent,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_LOW  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [PW-1:0] PH_ONE = PW'(1);
   localparam logic [NW-1:0] ED_ONE = NW'(1);

   state_t        state_q, state_d;
   logic [PW-1:0] hp_q, hp_d;        // latched half-period, never 0
   logic [NW-1:0] tgt_q, tgt_d;      // burst length, 0 = continuous
   logic [PW-1:0] cnt_q, cnt_d;      // phase counter, runs 1..hp
   logic [NW-1:0] edges_q, edges_d;
   logic          ring_q, ring_d;
   logic          accept;
   logic          phase_end;

   assign cfg_ready  = (state_q == S_IDLE) & ~stop & ~rst;
   assign accept     = cfg_valid & cfg_ready;
   assign phase_end  = (cnt_q == hp_q);

   assign ring_out   = ring_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign edges_sent = edges_q;
   assign dbg_state  = state_q;

   // Next-state and datapath: phase counter reloads to 1 on every phase change.
   always_comb begin
      state_d = state_q;
      hp_d    = hp_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
      edges_d = edges_q;
      ring_d  = ring_q;
      case (state_q)
         S_IDLE: begin
            ring_d = 1'b0;
            if (accept) begin
               hp_d    = (cfg_half_period == '0) ? PH_ONE : cfg_half_period;
               tgt_d   = cfg_edges;
               edges_d = ED_ONE;
               ring_d  = 1'b1;
               cnt_d   = PH_ONE;
               state_d = S_HIGH;
            end
         end
         S_HIGH: begin
            if (stop) begin
               ring_d  = 1'b0;
               state_d = S_IDLE;
            end else if (phase_end) begin
               ring_d  = 1'b0;
               cnt_d   = PH_ONE;
               state_d = S_LOW;
            end else begin
               cnt_d = cnt_q + PH_ONE;
            end
         end
         S_LOW: begin
            if (stop) begin
               ring_d  = 1'b0;
               state_d = S_IDLE;
            end else if (phase_end) begin
               if ((tgt_q != '0) && (edges_q == tgt_q)) begin
                  state_d = S_DONE;
               end else begin
                  ring_d  = 1'b1;
                  edges_d = edges_q + ED_ONE;   // wraps freely in continuous mode
                  cnt_d   = PH_ONE;
                  state_d = S_HIGH;
               end
            end else begin
               cnt_d = cnt_q + PH_ONE;
            end
         end
         S_DONE: begin
            // stop is deliberately ignored here so done always pulses
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            ring_d  = 1'b0;
         end
      endcase
   end

   // State register; rst overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         hp_q    <= PH_ONE;
         tgt_q   <= '0;
         cnt_q   <= PH_ONE;
         edges_q <= '0;
         ring_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hp_q    <= hp_d;
         tgt_q   <= tgt_d;
         cnt_q   <= cnt_d;
         edges_q <= edges_d;
         ring_q  <= ring_d;
      end
   end

endmodule
